td4_cpu: RTL and testbench
==========================

Name: td4_cpu

Overview:
- 4-bit TD4-class CPU core that executes one 8-bit instruction per clock from an external 16-word program memory.
- Program memory interface: combinational address out (A) and instruction in (D).
- Registers: A, B, 4-bit output latch, carry flag, 4-bit program counter.
- Sits between the top-level program ROM and the board I/O (4-bit IN switches, 4-bit OUT LEDs).

Parameters:
- RESET_PC, 4'd0, program counter value loaded on reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  synchronous, active-high reset.
- A  output  4  program memory address; combinationally equal to the PC.
- D  input  8  instruction word from program memory; D[7:4] is the opcode, D[3:0] is the immediate Im.
- IN  input  4  input port, sampled on the rising edge by IN instructions.
- OUT  output  4  output port; registered.

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high (CLR).
- Rising edge with CLR=1:
  - PC <= RESET_PC.
  - Registers A, B <= 0; carry C <= 0; OUT <= 0.
  - CLR overrides any instruction fetched that cycle.
- Rising edge with CLR=0: execute instruction D, then update state.
- Execution is single-cycle: fetch, decode and writeback all complete in the same cycle. An effect is visible on outputs one edge after the instruction is presented.
- Default next PC: PC+1, 4-bit wrap (15 -> 0).
- Opcode table (all others: NOP):
  - 0000 ADD A,Im: {C,A} <= A+Im.
  - 0101 ADD B,Im: {C,B} <= B+Im.
  - 0011 MOV A,Im: A <= Im.
  - 0111 MOV B,Im: B <= Im.
  - 0001 MOV A,B: A <= B.
  - 0100 MOV B,A: B <= A.
  - 0010 IN A: A <= IN.
  - 0110 IN B: B <= IN.
  - 1001 OUT B: OUT <= B.
  - 1011 OUT Im: OUT <= Im.
  - 1111 JMP Im: PC <= Im.
  - 1110 JNC Im: PC <= Im if C==0, else PC+1.
- Carry flag rules:
  - C is written every executed instruction.
  - ADD writes the 5th bit of the 4-bit sum.
  - Every other instruction, including JNC, NOP and undefined opcodes, writes C <= 0.
  - JNC tests the C value left by the immediately preceding instruction.
- Undefined opcodes (1000, 1010, 1100, 1101): NOP. PC+1, C <= 0, no other state change.
- Arithmetic: 4-bit unsigned, no saturation. Overflow wraps and sets C.
- Outputs:
  - OUT holds its value until the next OUT instruction or reset.
  - A changes only as a consequence of a PC change.
- Jumps: JMP Im to its own address is a legal infinite loop (halt idiom).

Optional Feature:
- Macro TD4_CARRY_OUT_EN.
- Defined: adds output port CF (1 bit), driven directly by the carry flag register. CF is reset to 0 with the other state.
- Not defined: no CF port; carry is internal only. Instruction behaviour is identical in both builds.

Test Plan:
- Reset: hold CLR=1 for 2 edges with arbitrary D -> A=0, OUT=0. Release CLR -> A steps 0,1,2 on successive edges.
- Immediate output: ROM[0]=8'b1011_0101 (OUT 5), ROM[1]=8'b1111_0001 (JMP 1) -> OUT=5 after the first post-reset edge; A stays 1 forever after.
- Add/carry/JNC:
  - ROM program: MOV A,15; ADD A,1; JNC 0; OUT Im=0xA; JMP 4.
  - Required: A=0, carry set, JNC not taken, OUT=0xA, PC loops at 4.
  - Variant with ADD A,0: JNC is taken back to 0 and OUT stays 0.
- Register moves and input:
  - Program: IN A with IN=0x9; MOV B,A; ADD B,3; OUT B.
  - Required: OUT=0xC on the edge after the OUT B instruction.
- PC wrap and NOP: ROM filled with opcode 1000 -> A counts 0..15 then 0; OUT stays 0.
- Mid-run reset: assert CLR for one edge while a loop is executing -> PC, A, B, C and OUT all 0 on that edge. Execution restarts from address 0.

Source files
------------

// File: rtl/td4_cpu.sv
// TD4-class 4-bit CPU: one 8-bit instruction per clock from a 16-word ROM.
// Optional TD4_CARRY_OUT_EN exposes the carry flag on port CF.
module td4_cpu #(
  parameter logic [3:0] RESET_PC = 4'd0
) (
  input  logic       CLK,
  input  logic       CLR,
  output logic [3:0] A,
  input  logic [7:0] D,
  input  logic [3:0] IN,
  output logic [3:0] OUT
`ifdef TD4_CARRY_OUT_EN
  ,
  output logic       CF
`endif
);

  typedef enum logic [3:0] {
    OP_ADD_A = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A  = 4'b0010,
    OP_MOV_A = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B = 4'b0101,
    OP_IN_B  = 4'b0110,
    OP_MOV_B = 4'b0111,
    OP_OUT_B = 4'b1001,
    OP_OUT_I = 4'b1011,
    OP_JNC   = 4'b1110,
    OP_JMP   = 4'b1111
  } op_e;

  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] out_q, out_d;
  logic       c_q, c_d;

  logic [3:0] op;
  logic [3:0] im;
  logic [4:0] sum_a;
  logic [4:0] sum_b;

  assign op    = D[7:4];
  assign im    = D[3:0];
  assign sum_a = {1'b0, a_q} + {1'b0, im};
  assign sum_b = {1'b0, b_q} + {1'b0, im};

  // Carry is rewritten every cycle; only ADD can leave it set.
  always_comb begin
    pc_d  = pc_q + 4'd1;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    c_d   = 1'b0;
    case (op)
      OP_ADD_A:  {c_d, a_d} = sum_a;
      OP_ADD_B:  {c_d, b_d} = sum_b;
      OP_MOV_A:  a_d = im;
      OP_MOV_B:  b_d = im;
      OP_MOV_AB: a_d = b_q;
      OP_MOV_BA: b_d = a_q;
      OP_IN_A:   a_d = IN;
      OP_IN_B:   b_d = IN;
      OP_OUT_B:  out_d = b_q;
      OP_OUT_I:  out_d = im;
      OP_JMP:    pc_d = im;
      OP_JNC:    if (!c_q) pc_d = im;
      default:   ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      pc_q  <= RESET_PC;
      a_q   <= 4'd0;
      b_q   <= 4'd0;
      out_q <= 4'd0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
      c_q   <= c_d;
    end
  end

  assign A   = pc_q;
  assign OUT = out_q;

`ifdef TD4_CARRY_OUT_EN
  assign CF = c_q;
`endif

endmodule

// File: tb/tb_td4_cpu.sv
// Self-checking bench for td4_cpu: directed program table,
// hand-written reset sequences and random programs against a model.
module tb_td4_cpu;

  logic       CLK;
  logic       CLR;
  logic [3:0] A;
  logic [7:0] D;
  logic [3:0] IN;
  logic [3:0] OUT;
`ifdef TD4_CARRY_OUT_EN
  logic       CF;
`endif

  logic [7:0] rom [16];

  int n_cmp;
  int n_bad;

  int m_pc, m_a, m_b, m_c, m_out;

  assign D = rom[A];

  td4_cpu dut (
    .CLK (CLK),
    .CLR (CLR),
    .A   (A),
    .D   (D),
    .IN  (IN),
    .OUT (OUT)
`ifdef TD4_CARRY_OUT_EN
    ,
    .CF  (CF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string            name;
    logic [15:0][7:0] prog;
    logic [3:0]       in_val;
    int               cycles;
    logic [3:0]       exp_a;
    logic [3:0]       exp_out;
  } vec_t;

  vec_t vecs [6];

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic.
  task automatic model_step(input bit clr, input int in_v);
    int ins, op, im, s, nxt, cn;
    if (clr) begin
      m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
      return;
    end
    ins = int'(rom[m_pc]);
    op  = ins / 16;
    im  = ins % 16;
    nxt = (m_pc + 1) % 16;
    cn  = 0;
    case (op)
      0:  begin s = m_a + im; m_a = s % 16; cn = (s > 15) ? 1 : 0; end
      5:  begin s = m_b + im; m_b = s % 16; cn = (s > 15) ? 1 : 0; end
      3:  m_a = im;
      7:  m_b = im;
      1:  m_a = m_b;
      4:  m_b = m_a;
      2:  m_a = in_v;
      6:  m_b = in_v;
      9:  m_out = m_b;
      11: m_out = im;
      15: nxt = im;
      14: if (m_c == 0) nxt = im;
      default: ;
    endcase
    m_c  = cn;
    m_pc = nxt;
  endtask

  task automatic step_chk(input string nm);
    model_step(CLR, int'(IN));
    @(posedge CLK);
    #1;
    cmp({nm, ".A"}, int'(A), m_pc);
    cmp({nm, ".OUT"}, int'(OUT), m_out);
  endtask

  task automatic load(input logic [15:0][7:0] p);
    for (int i = 0; i < 16; i++) rom[i] = p[i];
  endtask

  task automatic do_reset(input string nm);
    CLR = 1'b1;
    step_chk(nm);
    CLR = 1'b0;
  endtask

  initial begin
    logic [15:0][7:0] p;
    n_cmp = 0;
    n_bad = 0;
    CLR = 1'b0;
    IN = 4'd0;
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);

    // Reset held two edges with arbitrary instructions on D
    @(negedge CLK);
    CLR = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    m_pc = 0; m_a = 0; m_b = 0; m_c = 0; m_out = 0;
    cmp("rst.A", int'(A), 0);
    cmp("rst.OUT", int'(OUT), 0);
    CLR = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    @(posedge CLK); #1;
    cmp("rst.step1", int'(A), 1);
    @(posedge CLK); #1;
    cmp("rst.step2", int'(A), 2);

    p = '0;
    p[0] = 8'hB5; p[1] = 8'hF1;
    vecs[0] = '{"out_imm", p, 4'h0, 6, 4'h1, 4'h5};
    p = '0;
    p[0] = 8'h3F; p[1] = 8'h01; p[2] = 8'hE0; p[3] = 8'hBA; p[4] = 8'hF4;
    vecs[1] = '{"carry", p, 4'h0, 8, 4'h4, 4'hA};
    p[1] = 8'h00;
    vecs[2] = '{"nocarry", p, 4'h0, 8, 4'h2, 4'h0};
    p = '0;
    p[0] = 8'h29; p[1] = 8'h40; p[2] = 8'h53; p[3] = 8'h90; p[4] = 8'hF4;
    p[0] = 8'h20;
    vecs[3] = '{"moves", p, 4'h9, 5, 4'h4, 4'hC};
    for (int i = 0; i < 16; i++) p[i] = 8'h80;
    vecs[4] = '{"nop15", p, 4'h0, 15, 4'hF, 4'h0};
    vecs[5] = '{"nopwrap", p, 4'h0, 16, 4'h0, 4'h0};

    foreach (vecs[v]) begin
      load(vecs[v].prog);
      IN = vecs[v].in_val;
      do_reset({vecs[v].name, ".rst"});
      for (int c = 0; c < vecs[v].cycles; c++) step_chk(vecs[v].name);
      cmp({vecs[v].name, ".finalA"}, int'(A), int'(vecs[v].exp_a));
      cmp({vecs[v].name, ".finalOUT"}, int'(OUT), int'(vecs[v].exp_out));
    end

    // Mid-run reset must clear B: OUT B right after restart shows 0
    p = '0;
    p[0] = 8'h90; p[1] = 8'h77; p[2] = 8'h90; p[3] = 8'hF1;
    load(p);
    do_reset("midB.rst0");
    for (int c = 0; c < 7; c++) step_chk("midB.run");
    cmp("midB.pre", int'(OUT), 7);
    do_reset("midB.rst");
    cmp("midB.rstA", int'(A), 0);
    cmp("midB.rstOUT", int'(OUT), 0);
    step_chk("midB.post");
    cmp("midB.postOUT", int'(OUT), 0);

    // Mid-run reset while carry is set must clear it: JNC 4 is taken
    p = '0;
    p[0] = 8'hE4; p[1] = 8'hB3; p[2] = 8'hF2;
    p[4] = 8'hB6; p[5] = 8'h3F; p[6] = 8'h01; p[7] = 8'hF7;
    load(p);
    do_reset("midC.rst0");
    for (int c = 0; c < 4; c++) step_chk("midC.run");
    cmp("midC.atADD", int'(A), 7);
    do_reset("midC.rst");
    cmp("midC.rstA", int'(A), 0);
    cmp("midC.rstOUT", int'(OUT), 0);
    step_chk("midC.jnc");
    step_chk("midC.out");
    cmp("midC.A", int'(A), 5);
    cmp("midC.OUT", int'(OUT), 6);

    // Random programs, inputs and occasional resets against the model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      do_reset("rnd.rst");
      for (int c = 0; c < 60; c++) begin
        IN  = 4'($urandom);
        CLR = ($urandom_range(0, 39) == 0);
        step_chk("rnd");
      end
      CLR = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
